// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
// Optional feature macro: RF_SCHED_BYPASS_EN (queue-to-decode bypass).
package rf_sched_pkg;

  localparam int         PEND_DEPTH_DEF = 2;
  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam logic [4:0] REG_RA         = 5'd31;

  typedef struct packed {
    logic [4:0]  Rw;
    logic [31:0] busW;
  } pend_entry_t;

endpackage

// File: rtl/rf_pend_fifo.sv
// Circular pending-result queue for late multicycle results.
// With RF_SCHED_BYPASS_EN every slot and its occupancy is exposed so the
// scheduler can search the queue by destination register.
module rf_pend_fifo
  import rf_sched_pkg::*;
#(
  parameter int DEPTH = PEND_DEPTH_DEF,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  pend_entry_t             push_entry,
  input  logic                    pop,
  output pend_entry_t             head,
  output logic [CW-1:0]           count
`ifdef RF_SCHED_BYPASS_EN
  , output logic [DEPTH-1:0]      ent_valid
  , output pend_entry_t [DEPTH-1:0] ent
`endif
);

  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] tail_ptr_q, tail_ptr_d;
  logic [CW-1:0] count_q, count_d;
  pend_entry_t   mem_q [DEPTH];
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Guard against overflow/underflow; the caller normally never requests either.
  always_comb begin
    do_push    = push && (count_q != CW'(DEPTH));
    do_pop     = pop && (count_q != '0);
    head_ptr_d = do_pop  ? ptr_inc(head_ptr_q) : head_ptr_q;
    tail_ptr_d = do_push ? ptr_inc(tail_ptr_q) : tail_ptr_q;
    count_d    = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy state; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  // Slot storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_ptr_q] <= push_entry;
  end

  assign head  = mem_q[head_ptr_q];
  assign count = count_q;

`ifdef RF_SCHED_BYPASS_EN
  // A slot is live when its distance from head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PW:0] off;
    assign off = (gi >= int'(head_ptr_q)) ? (PW+1)'(gi - int'(head_ptr_q))
                                          : (PW+1)'(gi + DEPTH - int'(head_ptr_q));
    assign ent_valid[gi] = int'(off) < int'(count_q);
    assign ent[gi]       = mem_q[gi];
  end
`endif

endmodule

// File: rtl/rf_wr_sched.sv
// Register-file write-port scheduler and multicycle busy scoreboard.
// WB always owns the write port; queued multicycle results drain into idle
// slots. Optional feature macro: RF_SCHED_BYPASS_EN.
module rf_wr_sched
  import rf_sched_pkg::*;
#(
  parameter int PEND_DEPTH = PEND_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_WrEn,
  input  logic [4:0]  wb_Rw,
  input  logic [31:0] wb_busW,
  input  logic        wb_R31Wr,
  input  logic [29:0] wb_R31,
  input  logic        mc_issue,
  input  logic [4:0]  mc_Rd,
  input  logic        mc_valid,
  input  logic [4:0]  mc_Rw,
  input  logic [31:0] mc_busW,
  output logic        mc_ready,
  input  logic [4:0]  dec_Ra,
  input  logic [4:0]  dec_Rb,
  input  logic [4:0]  dec_Rw,
  input  logic        dec_RegWr,
  output logic        stall,
  output logic        rf_WrEn,
  output logic [4:0]  rf_Rw,
  output logic [31:0] rf_busW,
  output logic        rf_R31Wr,
  output logic [29:0] rf_R31,
  output logic [31:0] busy
`ifdef RF_SCHED_BYPASS_EN
  , output logic        byp_A_en
  , output logic [31:0] byp_A
  , output logic        byp_B_en
  , output logic [31:0] byp_B
`endif
);

  localparam int CW = $clog2(PEND_DEPTH + 1);

  pend_entry_t   head;
  logic [CW-1:0] count;
  logic          drain, push, issue_ok;
  logic          stall_a, stall_b;
  logic [31:0]   busy_q, busy_d;

`ifdef RF_SCHED_BYPASS_EN
  logic [PEND_DEPTH-1:0]      ent_valid;
  pend_entry_t [PEND_DEPTH-1:0] ent;
`endif

  rf_pend_fifo #(.DEPTH(PEND_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ({mc_Rw, mc_busW}),
    .pop        (drain),
    .head       (head),
    .count      (count)
`ifdef RF_SCHED_BYPASS_EN
    , .ent_valid (ent_valid)
    , .ent       (ent)
`endif
  );

  assign mc_ready = (count < CW'(PEND_DEPTH));
  assign push     = mc_valid && mc_ready;
  // The head waits while WB owns the port, or while it targets r31 and the link port is also writing r31.
  assign drain    = (count != '0) && !wb_WrEn && !(head.Rw == REG_RA && wb_R31Wr);

  // Write-port mux: WB first, then the queue head; r0 entries are dropped silently.
  always_comb begin
    rf_WrEn = 1'b0;
    rf_Rw   = wb_Rw;
    rf_busW = wb_busW;
    if (wb_WrEn) begin
      rf_WrEn = 1'b1;
    end else if (drain) begin
      rf_WrEn = (head.Rw != REG_ZERO);
      rf_Rw   = head.Rw;
      rf_busW = head.busW;
    end
    if (!rst_n) rf_WrEn = 1'b0;
  end

  assign rf_R31Wr = wb_R31Wr && rst_n;
  assign rf_R31   = wb_R31;

`ifdef RF_SCHED_BYPASS_EN
  // Associative search of the queue for decode sources; one hit per register at most.
  always_comb begin
    logic hit_a, hit_b;
    hit_a = 1'b0;
    hit_b = 1'b0;
    byp_A = '0;
    byp_B = '0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (ent_valid[i] && ent[i].Rw == dec_Ra) begin
        hit_a = 1'b1;
        byp_A = ent[i].busW;
      end
      if (ent_valid[i] && ent[i].Rw == dec_Rb) begin
        hit_b = 1'b1;
        byp_B = ent[i].busW;
      end
    end
    byp_A_en = rst_n && busy_q[dec_Ra] && hit_a;
    byp_B_en = rst_n && busy_q[dec_Rb] && hit_b;
    stall_a  = busy_q[dec_Ra] && !hit_a;
    stall_b  = busy_q[dec_Rb] && !hit_b;
  end
`else
  assign stall_a = busy_q[dec_Ra];
  assign stall_b = busy_q[dec_Rb];
`endif

  assign stall    = stall_a || stall_b || (dec_RegWr && busy_q[dec_Rw]);
  assign issue_ok = mc_issue && !stall && (mc_Rd != REG_ZERO);

  // Scoreboard update: clear on drain, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (drain) busy_d[head.Rw] = 1'b0;
    if (issue_ok) busy_d[mc_Rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; reset forgets all outstanding destinations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: doc/rf_wr_sched.md
# rf_wr_sched

Write-port scheduler and scoreboard for the 32×32 register file in the pipelined datapath. Shares the single rf write port between the in-order WB stage (always wins) and a multicycle unit (mult/div) whose results arrive late, buffering those results in a small pending queue. Tracks outstanding multicycle destinations in a busy scoreboard and raises a decode stall on RAW/WAW hazards against them.

## Interface
- PEND_DEPTH, 2, pending-result queue entries (≥1)
- Clk  in  1  clock; rf writes on the following negedge
- Rst_n  in  1  asynchronous active-low reset
- wb_WrEn / wb_Rw / wb_busW  in  1/5/32  WB-stage write request
- wb_R31Wr / wb_R31  in  1/30  WB link write (bits 31:2)
- mc_issue / mc_Rd  in  1/5  multicycle op issued from decode, destination
- mc_valid / mc_Rw / mc_busW  in  1/5/32  multicycle result
- mc_ready  out  1  queue can accept result
- dec_Ra / dec_Rb / dec_Rw  in  5 each  decode sources and destination
- dec_RegWr  in  1  decode instruction writes dec_Rw
- stall  out  1  hold decode
- rf_WrEn / rf_Rw / rf_busW  out  1/5/32  to rf write port
- rf_R31Wr / rf_R31  out  1/30  to rf link port
- busy  out  32  scoreboard; bit 0 hardwired 0
- byp_A_en / byp_A / byp_B_en / byp_B  out  1/32/1/32  present only with RF_SCHED_BYPASS_EN

## Operation
- rf_R31Wr/rf_R31 = wb_R31Wr/wb_R31, combinational pass-through.
- rf_* write port: if wb_WrEn, pass WB fields through; else if drain, present queue head; else rf_WrEn=0.
- drain = queue non-empty && !wb_WrEn && !(head.Rw==31 && wb_R31Wr).
- Head with Rw==0: popped when drain holds, rf_WrEn=0.
- Result accepted when mc_valid && mc_ready; pushed at tail. mc_ready = (count < PEND_DEPTH), from registered count only.
- Pop on drain at posedge; push and pop in the same cycle leave count unchanged.
- busy[mc_Rd] set on mc_issue (mc_Rd≠0); cleared when the entry with that Rw drains. Same-cycle set and clear of one register: set wins.
- stall = (busy[dec_Ra]) | (busy[dec_Rb]) | (dec_RegWr && busy[dec_Rw]). At most one outstanding entry per register follows.
- mc_issue asserted during stall is ignored.

## Timing
- Reset (async): queue empty, count=0, busy=0, hence mc_ready=1, stall=0. While Rst_n low, rf_WrEn=rf_R31Wr=0 and byp_*_en=0.
- WB write: zero-cycle pass-through.
- MC result: accepted at edge N, earliest rf_WrEn in cycle N+1, busy clear visible at N+2.
- Reset mid-operation discards queued results and busy bits.

## Configuration
- RF_SCHED_BYPASS_EN defined: stall on dec_Ra/dec_Rb is suppressed when the busy register's result already sits in the queue. byp_X_en=1 and byp_X=entry data instead. WAW stall on dec_Rw is unchanged.
- Undefined: no byp_* ports; stall on any busy source.

## Structure
- Shared package rf_sched_pkg: PEND_DEPTH default, REG_ZERO=5'd0, REG_RA=5'd31, pend_entry_t {Rw[4:0], busW[31:0]}.
- Sub-module rf_pend_fifo: circular buffer with head/tail pointers and count.
- Under RF_SCHED_BYPASS_EN, rf_pend_fifo exposes per-entry Rw/data for the associative lookup.

## Test plan
- Reset, then idle -> mc_ready=1, stall=0, busy=0, rf_WrEn=0.
- mc_issue Rd=8; 3 cycles later mc_valid Rw=8 busW=5 with wb_WrEn=0 -> rf_WrEn=1 Rw=8 busW=5 next cycle; busy[8] clears; dec_Ra=8 stalls until then.
- mc result Rw=9 queued while wb_WrEn=1 Rw=10 for 3 cycles -> WB writes pass; Rw=9 drains the cycle wb_WrEn drops.
- Fill queue (PEND_DEPTH=2) under continuous wb_WrEn -> mc_ready=0; third result held until one drain.
- Head Rw=31 with wb_R31Wr=1 -> head held one cycle, then drains.
- With RF_SCHED_BYPASS_EN: queued Rw=12 busW=32'hA5, dec_Rb=12 -> stall=0, byp_B_en=1, byp_B=32'hA5.
